// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the clock's set-mode sequencer: state encodings, SetState width,
// button indices and small decode helpers used by the controller, clock top and Displayer.
package time_set_controller_pkg;

    localparam int SET_STATE_W = 3;

    typedef enum logic [SET_STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_ALM_HOUR = 3'd3,
        ST_ALM_MIN  = 3'd4
    } state_t;

    localparam int NUM_BTN  = 3;
    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;
    localparam int BTN_OK   = 2;

    function automatic logic is_set_state(input state_t s);
        return s inside {ST_SET_HOUR, ST_SET_MIN, ST_ALM_HOUR, ST_ALM_MIN};
    endfunction

    function automatic state_t mode_next(input state_t s);
        case (s)
            ST_RUN:      return ST_SET_HOUR;
            ST_SET_HOUR: return ST_SET_MIN;
            ST_SET_MIN:  return ST_ALM_HOUR;
            ST_ALM_HOUR: return ST_ALM_MIN;
            default:     return ST_RUN;
        endcase
    endfunction

    // Bit order: {Clk_Min, Clk_Hour, Clk_Add_Min, Clk_Add_Hour}
    function automatic logic [3:0] pulse_sel(input state_t s);
        case (s)
            ST_SET_HOUR: return 4'b0001;
            ST_SET_MIN:  return 4'b0010;
            ST_ALM_HOUR: return 4'b0100;
            ST_ALM_MIN:  return 4'b1000;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/time_set_controller_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, level debouncer and one-cycle rise strobe.
// After reset a stable low must be seen first, so a button held through reset never strobes.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic Clk,
    input  logic RST,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_armed;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_armed <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (!r_armed) begin
                // Unarmed: the counter measures a stable release instead of a level change
                if (!r_sync2) begin
                    if (r_cnt == CNT_LAST) begin
                        r_armed <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end else if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/time_set_controller.sv
// Set-mode sequencer: debounced buttons drive the mode FSM, increment pulses, idle timeout and blink.
// Optional SET_AUTOREPEAT_EN: a held BtnInc re-issues increments every REP_CYCLES cycles.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int PULSE_W    = 4,
    parameter int TIMEOUT_S  = 10,
    parameter int REP_CYCLES = 25_000_000
) (
    input  logic                   Clk,
    input  logic                   RST,
    input  logic                   tick_1hz,
    input  logic                   BtnMode,
    input  logic                   BtnInc,
    input  logic                   BtnOk,
    output logic                   EN,
    output logic                   EN_Alert,
    output logic                   Clk_Add_Hour,
    output logic                   Clk_Add_Min,
    output logic                   Clk_Hour,
    output logic                   Clk_Min,
    output logic                   BlinkHour,
    output logic                   BlinkMin,
    output logic [SET_STATE_W-1:0] SetState
);

    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam int PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;

    assign w_raw = {BtnOk, BtnInc, BtnMode};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .Clk    (Clk),
                .RST    (RST),
                .i_raw  (w_raw[gi]),
                .o_level(w_level[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_next;
    logic                w_ok;
    logic                w_mode;
    logic                w_inc;
    logic                w_timeout;
    logic                w_state_change;
    logic                w_inc_accept;
    logic                w_phase_next;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [3:0]          r_pulse;
    logic [PCNT_W-1:0]   r_pulse_cnt;
    logic                r_phase;
    logic                r_en;
    logic                r_en_alert;
    logic                r_blink_hour;
    logic                r_blink_min;

    assign w_ok   = w_rise[BTN_OK];
    assign w_mode = w_rise[BTN_MODE];

`ifdef SET_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REP_CYCLES + 1);
    logic [REP_W-1:0] r_rep_cnt;
    logic             w_rep;

    // Counter is 0 on the initial-press cycle, so repeats land REP_CYCLES apart
    assign w_rep = is_set_state(r_state) && w_level[BTN_INC] && (r_rep_cnt == REP_W'(REP_CYCLES));
    assign w_inc = w_rise[BTN_INC] | w_rep;

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_rep_cnt <= '0;
        end else if (!w_level[BTN_INC] || !is_set_state(r_state) || w_state_change) begin
            r_rep_cnt <= '0;
        end else if (w_rep) begin
            r_rep_cnt <= REP_W'(1);
        end else begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    assign w_inc = w_rise[BTN_INC];
`endif

    assign w_timeout = tick_1hz && is_set_state(r_state) && (r_idle_cnt == IDLE_W'(TIMEOUT_S - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_ALM_HOUR, ST_ALM_MIN: begin
                if (w_ok) begin
                    w_state_next = ST_RUN;
                end else if (w_mode) begin
                    w_state_next = mode_next(r_state);
                end else if (w_timeout) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_state_change = (w_state_next != r_state);
    assign w_inc_accept   = w_inc && !w_ok && !w_mode && is_set_state(r_state)
                            && !w_state_change && (r_pulse == 4'b0000);
    assign w_phase_next   = !is_set_state(w_state_next) ? 1'b0 :
                            (tick_1hz && is_set_state(r_state)) ? ~r_phase : r_phase;

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_pulse     <= 4'b0000;
            r_pulse_cnt <= '0;
        end else if (w_state_change) begin
            r_pulse     <= 4'b0000;
            r_pulse_cnt <= '0;
        end else if (w_inc_accept) begin
            r_pulse     <= pulse_sel(r_state);
            r_pulse_cnt <= PCNT_W'(PULSE_W - 1);
        end else if (r_pulse != 4'b0000) begin
            if (r_pulse_cnt == '0) begin
                r_pulse <= 4'b0000;
            end else begin
                r_pulse_cnt <= r_pulse_cnt - PCNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_idle_cnt   <= '0;
            r_phase      <= 1'b0;
            r_en         <= 1'b1;
            r_en_alert   <= 1'b0;
            r_blink_hour <= 1'b0;
            r_blink_min  <= 1'b0;
        end else begin
            if ((|w_rise) || w_inc || w_state_change) begin
                r_idle_cnt <= '0;
            end else if (tick_1hz && is_set_state(r_state) && (r_idle_cnt != IDLE_W'(TIMEOUT_S))) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
            r_phase      <= w_phase_next;
            r_en         <= !(w_state_next inside {ST_SET_HOUR, ST_SET_MIN});
            r_en_alert   <= (w_state_next inside {ST_ALM_HOUR, ST_ALM_MIN});
            r_blink_hour <= w_phase_next && (w_state_next inside {ST_SET_HOUR, ST_ALM_HOUR});
            r_blink_min  <= w_phase_next && (w_state_next inside {ST_SET_MIN, ST_ALM_MIN});
        end
    end

    assign EN           = r_en;
    assign EN_Alert     = r_en_alert;
    assign Clk_Add_Hour = r_pulse[0];
    assign Clk_Add_Min  = r_pulse[1];
    assign Clk_Hour     = r_pulse[2];
    assign Clk_Min      = r_pulse[3];
    assign BlinkHour    = r_blink_hour;
    assign BlinkMin     = r_blink_min;
    assign SetState     = r_state;

endmodule
